// File: rtl/i2c_pkg.sv
// Shared types and constants for the keypad I2C initiator.
// Holds the FSM state set, bit-phase encodings and the read-direction bit.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADRACK,
        ST_RD0,
        ST_MACK,
        ST_RD1,
        ST_MNACK,
        ST_STOP,
        ST_GAP
    } state_t;

    localparam logic [1:0] PH_Q0 = 2'd0;
    localparam logic [1:0] PH_Q1 = 2'd1;
    localparam logic [1:0] PH_Q2 = 2'd2;
    localparam logic [1:0] PH_Q3 = 2'd3;

    localparam logic RW_READ   = 1'b1;
    localparam int   BIT_CNT_W = 3;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick generator: divider latched on load, phase counter Q0..Q3,
// and a freeze at the end of Q3 while a slave stretches SCL.
module i2c_tick_gen
    import i2c_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    input  logic             stretch,
    output logic             tick,
    output logic [1:0]       phase
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [1:0]       phase_q, phase_d;

    // Stretch is only judged at the final count of Q3 so the synchronizer
    // latency after releasing SCL never reads as a held line.
    assign tick  = run && (cnt_q == div_q) && !((phase_q == PH_Q3) && stretch);
    assign phase = phase_q;

    always_comb begin
        div_d   = div_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (load) begin
            div_d   = (div == '0) ? DIV_W'(1) : div;
            cnt_d   = '0;
            phase_d = PH_Q0;
        end else if (!run) begin
            cnt_d   = '0;
            phase_d = PH_Q0;
        end else if (tick) begin
            cnt_d   = '0;
            phase_d = phase_q + 2'd1;
        end else if (cnt_q != div_q) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            cnt_q   <= '0;
            phase_q <= PH_Q0;
        end else begin
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/i2c_keypad_master.sv
// I2C initiator that repeatedly reads a 2-byte keypad word from one slave
// while enabled, driving open-drain SCL/SDA pull-down enables.
module i2c_keypad_master
    import i2c_pkg::*;
#(
    parameter int         pI2CDivClk = 16,
    parameter logic [6:0] pSlaveAdrs = 7'h20
) (
    input  logic                  iSysClk,
    input  logic                  iSysRst,
    input  logic                  iI2CEn,
    input  logic [pI2CDivClk-1:0] iI2CDiv,
    input  logic                  iScl,
    input  logic                  iSda,
    output logic                  oSclOe,
    output logic                  oSdaOe,
    output logic [15:0]           oI2CGetKeyPad,
    output logic                  oI2CKeyVd,
    output logic                  oI2CBusy,
    output logic                  oI2CNack
);

    state_t                 state_q, state_d;
    logic [BIT_CNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             byte0_q, byte0_d;
    logic [7:0]             byte1_q, byte1_d;
    logic [15:0]            key_q, key_d;
    logic                   vd_q, vd_d;
    logic                   busy_q, busy_d;
    logic                   nack_q, nack_d;
    logic                   ack_ok_q, ack_ok_d;
    logic                   scl_oe_q, scl_oe_d;
    logic                   sda_oe_q, sda_oe_d;
    logic                   scl_meta_q, scl_meta_d, scl_sync_q, scl_sync_d;
    logic                   sda_meta_q, sda_meta_d, sda_sync_q, sda_sync_d;

    logic       tick;
    logic [1:0] phase;
    logic       load;
    logic       bit_end;
    logic       scl_low_phase;

    i2c_tick_gen #(.DIV_W(pI2CDivClk)) u_tick (
        .clk     (iSysClk),
        .rst     (iSysRst),
        .run     (state_q != ST_IDLE),
        .load    (load),
        .div     (iI2CDiv),
        .stretch (!scl_oe_q && !scl_sync_q),
        .tick    (tick),
        .phase   (phase)
    );

    assign bit_end       = tick && (phase == PH_Q3);
    assign scl_low_phase = (phase == PH_Q0) || (phase == PH_Q1);

    always_comb begin
        scl_meta_d = iScl;
        scl_sync_d = scl_meta_q;
        sda_meta_d = iSda;
        sda_sync_d = sda_meta_q;

        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        byte0_d  = byte0_q;
        byte1_d  = byte1_q;
        key_d    = key_q;
        vd_d     = 1'b0;
        nack_d   = nack_q;
        ack_ok_d = ack_ok_q;
        load     = 1'b0;
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (iI2CEn) begin
                    state_d = ST_START;
                    load    = 1'b1;
                end
            end
            ST_START: begin
                scl_oe_d = (phase == PH_Q3);
                sda_oe_d = (phase == PH_Q2) || (phase == PH_Q3);
                if (bit_end) begin
                    state_d  = ST_ADDR;
                    shift_d  = {pSlaveAdrs, RW_READ};
                    bitcnt_d = '0;
                    ack_ok_d = 1'b0;
                end
            end
            ST_ADDR: begin
                scl_oe_d = scl_low_phase;
                sda_oe_d = ~shift_q[7];
                if (bit_end) begin
                    shift_d  = {shift_q[6:0], 1'b0};
                    bitcnt_d = bitcnt_q + BIT_CNT_W'(1);
                    if (bitcnt_q == '1) state_d = ST_ADRACK;
                end
            end
            ST_ADRACK: begin
                scl_oe_d = scl_low_phase;
                if (bit_end) begin
                    bitcnt_d = '0;
                    if (sda_sync_q) begin
                        nack_d  = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        ack_ok_d = 1'b1;
                        state_d  = ST_RD0;
                    end
                end
            end
            ST_RD0, ST_RD1: begin
                scl_oe_d = scl_low_phase;
                if (bit_end) begin
                    shift_d  = {shift_q[6:0], sda_sync_q};
                    bitcnt_d = bitcnt_q + BIT_CNT_W'(1);
                    if (bitcnt_q == '1) begin
                        if (state_q == ST_RD0) begin
                            byte0_d = {shift_q[6:0], sda_sync_q};
                            state_d = ST_MACK;
                        end else begin
                            byte1_d = {shift_q[6:0], sda_sync_q};
                            state_d = ST_MNACK;
                        end
                    end
                end
            end
            ST_MACK: begin
                scl_oe_d = scl_low_phase;
                sda_oe_d = 1'b1;
                if (bit_end) begin
                    bitcnt_d = '0;
                    state_d  = ST_RD1;
                end
            end
            ST_MNACK: begin
                scl_oe_d = scl_low_phase;
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                // SCL rises at Q1 with SDA low; SDA rising at Q2 forms the stop.
                scl_oe_d = (phase == PH_Q0);
                sda_oe_d = scl_low_phase;
                if (bit_end) begin
                    state_d = ST_GAP;
                    if (ack_ok_q) begin
                        key_d  = {byte0_q, byte1_q};
                        vd_d   = 1'b1;
                        nack_d = 1'b0;
                    end
                end
            end
            ST_GAP: begin
                if (bit_end) begin
                    if (iI2CEn) begin
                        state_d = ST_START;
                        load    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE) && (state_d != ST_GAP);
    end

    always_ff @(posedge iSysClk or posedge iSysRst) begin
        if (iSysRst) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            byte0_q    <= '0;
            byte1_q    <= '0;
            key_q      <= '0;
            vd_q       <= 1'b0;
            busy_q     <= 1'b0;
            nack_q     <= 1'b0;
            ack_ok_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            byte0_q    <= byte0_d;
            byte1_q    <= byte1_d;
            key_q      <= key_d;
            vd_q       <= vd_d;
            busy_q     <= busy_d;
            nack_q     <= nack_d;
            ack_ok_q   <= ack_ok_d;
            scl_oe_q   <= scl_oe_d;
            sda_oe_q   <= sda_oe_d;
            scl_meta_q <= scl_meta_d;
            scl_sync_q <= scl_sync_d;
            sda_meta_q <= sda_meta_d;
            sda_sync_q <= sda_sync_d;
        end
    end

    assign oSclOe        = scl_oe_q;
    assign oSdaOe        = sda_oe_q;
    assign oI2CGetKeyPad = key_q;
    assign oI2CKeyVd     = vd_q;
    assign oI2CBusy      = busy_q;
    assign oI2CNack      = nack_q;

endmodule

// File: tb/tb_i2c_keypad_master.sv
// Bench for i2c_keypad_master: behavioural open-drain slave plus a keypad
// scoreboard fed by each scenario task.
module tb_i2c_keypad_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [15:0] div = 16'd3;
    logic        scl_oe, sda_oe, vd, busy, nack;
    logic [15:0] key;
    logic        slv_sda_low = 1'b0;
    logic        slv_scl_low = 1'b0;

    wire scl_bus = !(scl_oe || slv_scl_low);
    wire sda_bus = !(sda_oe || slv_sda_low);

    i2c_keypad_master #(.pI2CDivClk(16), .pSlaveAdrs(7'h20)) dut (
        .iSysClk       (clk),
        .iSysRst       (rst),
        .iI2CEn        (en),
        .iI2CDiv       (div),
        .iScl          (scl_bus),
        .iSda          (sda_bus),
        .oSclOe        (scl_oe),
        .oSdaOe        (sda_oe),
        .oI2CGetKeyPad (key),
        .oI2CKeyVd     (vd),
        .oI2CBusy      (busy),
        .oI2CNack      (nack)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_last = 16'h0000;

    // slave configuration, snapshotted at each START
    bit          slv_ack = 1'b1;
    bit          slv_stretch = 1'b0;
    logic [7:0]  slv_b0 = 8'h00, slv_b1 = 8'h00;

    int          nrise = 0, nfall = 0, nstart = 0, nstop = 0, stretch_cnt = 0;
    int          rise_t[0:31];
    logic [7:0]  addr_cap = 8'h00, cur_b0 = 8'h00, cur_b1 = 8'h00;
    logic        mack_cap = 1'b0, mnack_cap = 1'b0;
    bit          cur_ack = 1'b0, cur_str = 1'b0;
    logic        scl_prev = 1'b1, sda_prev = 1'b1;

    int          cyc = 0, busy_rise = 0, busy_fall = 0, vd_cnt = 0, vd_cyc = 0;
    logic        busy_prev = 1'b0, vd_prev = 1'b0;

    initial begin
        logic        s, d;
        logic [15:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b1 && !busy_prev) busy_rise = cyc;
            if (busy === 1'b0 && busy_prev)  busy_fall = cyc;
            busy_prev = (busy === 1'b1);
            if (vd === 1'b1) begin
                if (vd_prev) begin
                    total++; bad++;
                    $display("FAIL keyvd_width: still high at cycle %0d, required 1-cycle pulse", cyc);
                end else begin
                    vd_cnt++;
                    vd_cyc = cyc;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL keyvd_unexpected: key=%h with no expected word", key);
                    end else begin
                        e = exp_q.pop_front();
                        exp_last = e;
                        if (key !== e) begin
                            bad++;
                            $display("FAIL keypad_word: got=%h exp=%h", key, e);
                        end
                    end
                end
            end
            vd_prev = (vd === 1'b1);

            s = scl_bus;
            d = sda_bus;
            if (s && scl_prev && sda_prev && !d) begin
                nstart++;
                nrise = 0; nfall = 0; addr_cap = 8'h00;
                cur_ack = slv_ack; cur_str = slv_stretch;
                cur_b0 = slv_b0; cur_b1 = slv_b1;
            end else if (s && scl_prev && !sda_prev && d) begin
                nstop++;
            end
            if (s && !scl_prev) begin
                nrise++;
                if (nrise < 32) rise_t[nrise] = cyc;
                if (nrise <= 8) addr_cap = {addr_cap[6:0], d};
                if (nrise == 18) mack_cap = d;
                if (nrise == 27) mnack_cap = d;
            end
            if (stretch_cnt > 0) begin
                stretch_cnt--;
                if (stretch_cnt == 0) slv_scl_low = 1'b0;
            end
            if (!s && scl_prev) begin
                nfall++;
                slv_sda_low = 1'b0;
                if (cur_ack) begin
                    if (nfall == 9) slv_sda_low = 1'b1;
                    else if (nfall >= 10 && nfall <= 17) slv_sda_low = !cur_b0[17-nfall];
                    else if (nfall >= 19 && nfall <= 26) slv_sda_low = !cur_b1[26-nfall];
                    if (nfall == 13 && cur_str) begin
                        stretch_cnt = 40;
                        slv_scl_low = 1'b1;
                    end
                end
            end
            scl_prev = s;
            sda_prev = d;
        end
    end

    task automatic wait_busy(input logic lvl, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (busy === lvl) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_vd(input int v0, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (vd_cnt > v0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total += 6;
        if (scl_oe !== 1'b0) begin bad++; $display("FAIL rst_scl_oe got=%b exp=0", scl_oe); end
        if (sda_oe !== 1'b0) begin bad++; $display("FAIL rst_sda_oe got=%b exp=0", sda_oe); end
        if (key !== 16'h0000) begin bad++; $display("FAIL rst_key got=%h exp=0000", key); end
        if (vd !== 1'b0) begin bad++; $display("FAIL rst_vd got=%b exp=0", vd); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (nack !== 1'b0) begin bad++; $display("FAIL rst_nack got=%b exp=0", nack); end
        $display("reset: outputs idle");
    endtask

    task automatic test_basic();
        bit ok;
        int s0, v0;
        slv_ack = 1'b1; slv_b0 = 8'hA5; slv_b1 = 8'h3C; div = 16'd3;
        exp_q.push_back(16'hA53C);
        s0 = nstop; v0 = vd_cnt;
        en = 1'b1;
        wait_busy(1'b1, 100, ok);
        en = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL basic_start got=timeout exp=busy"); end
        wait_vd(v0, 2000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_vd got=timeout exp=keyvd"); end
        total += 6;
        if (addr_cap !== 8'h41) begin bad++; $display("FAIL basic_addr got=%h exp=41", addr_cap); end
        if (mack_cap !== 1'b0) begin bad++; $display("FAIL basic_mack got=%b exp=0", mack_cap); end
        if (mnack_cap !== 1'b1) begin bad++; $display("FAIL basic_mnack got=%b exp=1", mnack_cap); end
        if (rise_t[2] - rise_t[1] != 16) begin bad++; $display("FAIL basic_scl_period got=%0d exp=16", rise_t[2] - rise_t[1]); end
        if (vd_cyc - busy_rise != 464) begin bad++; $display("FAIL basic_latency got=%0d exp=464", vd_cyc - busy_rise); end
        if (nstop != s0 + 1) begin bad++; $display("FAIL basic_stop got=%0d exp=%0d", nstop, s0 + 1); end
        repeat (40) @(negedge clk);
        $display("basic: addr=%h key=%h latency=%0d", addr_cap, key, vd_cyc - busy_rise);
    endtask

    task automatic test_nack_back_to_back();
        bit ok;
        int v0;
        slv_ack = 1'b0; slv_b0 = 8'hFF; slv_b1 = 8'hFF; div = 16'd3;
        v0 = vd_cnt;
        en = 1'b1;
        wait_busy(1'b1, 100, ok);
        wait_busy(1'b0, 1000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL nack_end got=timeout exp=busy_low"); end
        total += 5;
        if (busy_fall - busy_rise != 176) begin bad++; $display("FAIL nack_len got=%0d exp=176", busy_fall - busy_rise); end
        if (nack !== 1'b1) begin bad++; $display("FAIL nack_flag got=%b exp=1", nack); end
        if (key !== exp_last) begin bad++; $display("FAIL nack_key_hold got=%h exp=%h", key, exp_last); end
        if (vd_cnt != v0) begin bad++; $display("FAIL nack_no_vd got=%0d exp=%0d", vd_cnt, v0); end
        if (nrise != 10) begin bad++; $display("FAIL nack_stop_pos got=%0d exp=10", nrise); end
        slv_ack = 1'b1; slv_b0 = 8'h12; slv_b1 = 8'h34;
        exp_q.push_back(16'h1234);
        wait_busy(1'b1, 100, ok);
        en = 1'b0;
        total++;
        if (busy_rise - busy_fall != 16) begin bad++; $display("FAIL gap_len got=%0d exp=16", busy_rise - busy_fall); end
        wait_vd(v0, 2000, ok);
        total += 2;
        if (!ok) begin bad++; $display("FAIL nack_recover_vd got=timeout exp=keyvd"); end
        if (nack !== 1'b0) begin bad++; $display("FAIL nack_cleared got=%b exp=0", nack); end
        repeat (40) @(negedge clk);
        $display("nack: sticky then cleared, key=%h", key);
    endtask

    task automatic test_div0();
        bit ok;
        int v0;
        slv_ack = 1'b1; slv_b0 = 8'hC3; slv_b1 = 8'h81; div = 16'd0;
        exp_q.push_back(16'hC381);
        v0 = vd_cnt;
        en = 1'b1;
        wait_busy(1'b1, 100, ok);
        en = 1'b0;
        div = 16'd9;
        wait_vd(v0, 2000, ok);
        total += 4;
        if (!ok) begin bad++; $display("FAIL div0_vd got=timeout exp=keyvd"); end
        if (rise_t[2] - rise_t[1] != 8) begin bad++; $display("FAIL div0_period got=%0d exp=8", rise_t[2] - rise_t[1]); end
        if (rise_t[6] - rise_t[5] != 8) begin bad++; $display("FAIL div_change_ignored got=%0d exp=8", rise_t[6] - rise_t[5]); end
        if (vd_cyc - busy_rise != 232) begin bad++; $display("FAIL div0_latency got=%0d exp=232", vd_cyc - busy_rise); end
        div = 16'd3;
        repeat (40) @(negedge clk);
        $display("div0: period=%0d latency=%0d", rise_t[2] - rise_t[1], vd_cyc - busy_rise);
    endtask

    task automatic test_stretch();
        bit ok;
        int v0, dur;
        slv_ack = 1'b1; slv_b0 = 8'h96; slv_b1 = 8'h0F; slv_stretch = 1'b1; div = 16'd3;
        exp_q.push_back(16'h960F);
        v0 = vd_cnt;
        en = 1'b1;
        wait_busy(1'b1, 100, ok);
        en = 1'b0;
        wait_vd(v0, 3000, ok);
        slv_stretch = 1'b0;
        dur = vd_cyc - busy_rise;
        total += 2;
        if (!ok) begin bad++; $display("FAIL stretch_vd got=timeout exp=keyvd"); end
        if (dur <= 479 || dur >= 509) begin bad++; $display("FAIL stretch_len got=%0d exp=480..508", dur); end
        repeat (40) @(negedge clk);
        $display("stretch: latency=%0d key=%h", dur, key);
    endtask

    task automatic test_en_drop();
        bit ok, act;
        int v0, s0;
        slv_ack = 1'b1; slv_b0 = 8'h55; slv_b1 = 8'hAA; div = 16'd3;
        exp_q.push_back(16'h55AA);
        v0 = vd_cnt; s0 = nstart;
        en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (nstart > s0 && nrise >= 20) begin ok = 1'b1; break; end
        end
        en = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL endrop_reach_rd1 got=timeout exp=rd1"); end
        wait_vd(v0, 2000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL endrop_vd got=timeout exp=keyvd"); end
        s0 = nstart;
        act = 1'b0;
        repeat (300) begin
            @(negedge clk); #1;
            if (busy !== 1'b0 || scl_oe !== 1'b0) act = 1'b1;
        end
        total += 2;
        if (act) begin bad++; $display("FAIL endrop_idle got=activity exp=idle"); end
        if (nstart != s0) begin bad++; $display("FAIL endrop_no_start got=%0d exp=%0d", nstart, s0); end
        $display("en_drop: completed key=%h then idle", key);
    endtask

    task automatic test_async_reset();
        bit ok;
        int s0;
        slv_ack = 1'b1; slv_b0 = 8'h01; slv_b1 = 8'h02; div = 16'd3;
        s0 = nstart;
        en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (nstart > s0 && nrise >= 3 && scl_oe === 1'b1 && sda_oe === 1'b1) begin ok = 1'b1; break; end
        end
        en = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL arst_reach_addr got=timeout exp=addr"); end
        #2 rst = 1'b1;
        #1;
        total += 6;
        if (scl_oe !== 1'b0) begin bad++; $display("FAIL arst_scl_oe got=%b exp=0", scl_oe); end
        if (sda_oe !== 1'b0) begin bad++; $display("FAIL arst_sda_oe got=%b exp=0", sda_oe); end
        if (key !== 16'h0000) begin bad++; $display("FAIL arst_key got=%h exp=0000", key); end
        if (vd !== 1'b0) begin bad++; $display("FAIL arst_vd got=%b exp=0", vd); end
        if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b exp=0", busy); end
        if (nack !== 1'b0) begin bad++; $display("FAIL arst_nack got=%b exp=0", nack); end
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        #1;
        total += 2;
        if (busy !== 1'b0) begin bad++; $display("FAIL arst_stays_idle got=%b exp=0", busy); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
        $display("async_reset: lines released mid-address");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nack_back_to_back();
        test_div0();
        test_stretch();
        test_en_drop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
